seq_checker: RTL

Receive-side checker for the 3-bit (a,b,c) sequence produced by the team's XOR/OR state generator. It samples the generator outputs, predicts each next triple from the generator's transition function, and acquires lock after a run of correct transitions. Once locked it flags and counts deviations, and it enters a sticky fail state when the error budget is exhausted. It sits next to the generator in the test harness as its self-checking consumer.

---
 rtl/seq_pkg.sv | 12 +
 rtl/seq_predict.sv | 29 ++
 rtl/seq_checker.sv | 83 ++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding, fixed-point constants and the generator transition function
package seq_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, TRACK, FAIL} state_t;
  localparam logic [2:0] FP0 = 3'b000;
  localparam logic [2:0] FP1 = 3'b011;
  localparam logic [2:0] FP2 = 3'b111;
  function automatic logic [2:0] seq_next(input logic [2:0] s);
    logic x;
    x = ^s;
    return {x, x | s[0], s[1]};
  endfunction
endpackage

// File: rtl/seq_predict.sv
// seq_predict: holds the last accepted sample and derives the predicted next sample and fixed-point flag
//   i_clk, i_reset, i_clear : clock, sync reset, soft clear
//   i_load, i_sample        : accept i_sample into the prev register
//   o_expected, o_fixed_pt  : f(prev), last accepted sample is a fixed point
module seq_predict
  import seq_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clear,
  input  logic       i_load,
  input  logic [2:0] i_sample,
  output logic [2:0] o_expected,
  output logic       o_fixed_pt
);
  logic [2:0] r_prev;
  logic       r_fixed_pt;
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_prev     <= '0;
      r_fixed_pt <= 1'b0;
    end else if (i_load) begin
      r_prev     <= i_sample;
      r_fixed_pt <= i_sample == FP0 || i_sample == FP1 || i_sample == FP2;
    end
  end
  assign o_expected = seq_next(r_prev);
  assign o_fixed_pt = r_fixed_pt;
endmodule

// File: rtl/seq_checker.sv
// seq_checker: locks onto the XOR/OR generator stream, then counts deviations until the error budget fails it
//   i_clk, i_reset, i_clear, i_valid, i_sample : clock, sync reset, soft clear, qualifier, {a,b,c}
//   o_locked, o_mismatch, o_fail, o_fixed_pt, o_err_count, o_expected : status, error count, f(prev)
module seq_checker
  import seq_pkg::*;
#(
  parameter int LOCK_LEN = 4,
  parameter int MAX_ERR  = 3,
  parameter int CNT_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic [2:0]       i_sample,
  output logic             o_locked,
  output logic             o_mismatch,
  output logic             o_fail,
  output logic             o_fixed_pt,
  output logic [CNT_W-1:0] o_err_count,
  output logic [2:0]       o_expected
);
  state_t           r_state, w_state;
  logic [3:0]       r_good, w_good;
  logic [CNT_W-1:0] r_err, w_err, w_err_inc;
  logic             r_mismatch, w_mismatch, w_match;
  seq_predict u_predict (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clear    (i_clear),
    .i_load     (i_valid && !i_clear),
    .i_sample   (i_sample),
    .o_expected (o_expected),
    .o_fixed_pt (o_fixed_pt)
  );
  assign w_match   = i_sample == o_expected;
  assign w_err_inc = &r_err ? r_err : r_err + CNT_W'(1);
  always_comb begin
    w_state    = r_state;
    w_good     = r_good;
    w_err      = r_err;
    w_mismatch = 1'b0;
    if (i_clear) begin
      w_state = IDLE;
      w_good  = '0;
      w_err   = '0;
    end else if (i_valid) begin
      case (r_state)
        IDLE: begin
          w_state = SYNC;
          w_good  = '0;
        end
        SYNC: begin
          w_good  = w_match ? r_good + 4'd1 : 4'd0;
          w_state = w_match && r_good + 4'd1 == 4'(LOCK_LEN) ? TRACK : SYNC;
        end
        TRACK: if (!w_match) begin
          w_mismatch = 1'b1;
          w_err      = w_err_inc;
          w_state    = w_err_inc == CNT_W'(MAX_ERR) ? FAIL : TRACK;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_good     <= '0;
      r_err      <= '0;
      r_mismatch <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_good     <= w_good;
      r_err      <= w_err;
      r_mismatch <= w_mismatch;
    end
  end
  assign o_locked    = r_state == TRACK;
  assign o_fail      = r_state == FAIL;
  assign o_mismatch  = r_mismatch;
  assign o_err_count = r_err;
endmodule
